// File: rtl/swap_arb_pkg.sv
// Shared definitions for the swap arbiter: opcodes, FSM states and a width helper.
package swap_arb_pkg;

  localparam logic [1:0] OP_LDB  = 2'b00;
  localparam logic [1:0] OP_LDC  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/swap_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr (wrapping), as a one-hot grant.
module rr_pick
  import swap_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]               req,
  input  logic [clog2_min1(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]               grant_c,
  output logic                          valid_c
);

  localparam int unsigned PW = clog2_min1(NREQ);
  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  // Scan requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      idx = sum[PW-1:0];
      if (!valid_c && req[idx]) begin
        grant_c[idx] = 1'b1;
        valid_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/swap_arbiter.sv
// Round-robin arbiter granting one requester at a time access to shared registers
// b/c (load b, load c, swap, nop). Optional consecutive-swap watchdog enabled by
// defining SWAP_ARB_WDOG_EN.
module swap_arbiter
  import swap_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned B_INIT   = 0,
  parameter int unsigned C_INIT   = 1,
  parameter int unsigned WDOG_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [W-1:0]      b_q,
  output logic [W-1:0]      c_q,
  output logic              busy,
  output logic              wdog_trip
);

  localparam int unsigned PW = clog2_min1(NREQ);

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [1:0]     op_r;
  logic [W-1:0]   data_r;

  logic [NREQ-1:0] pick_gnt_c;
  logic            pick_valid_c;
  logic [PW-1:0]   pick_idx_c;
  logic [1:0]      pick_op_c;
  logic [W-1:0]    pick_data_c;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .grant_c (pick_gnt_c),
    .valid_c (pick_valid_c)
  );

  // Encode the picked requester and mux out its opcode and load data.
  always_comb begin
    pick_idx_c  = '0;
    pick_op_c   = OP_NOP;
    pick_data_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_gnt_c[i]) begin
        pick_idx_c  = PW'(i);
        pick_op_c   = op[2*i +: 2];
        pick_data_c = wdata[W*i +: W];
      end
    end
  end

`ifdef SWAP_ARB_WDOG_EN
  localparam int unsigned CW = clog2_min1(WDOG_MAX + 1);
  logic [CW-1:0] wdog_cnt;
`else
  assign wdog_trip = 1'b0;
`endif

  // Arbitration FSM; the operation is captured at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      b_q    <= W'(B_INIT);
      c_q    <= W'(C_INIT);
      ptr    <= '0;
      gidx   <= '0;
      op_r   <= OP_NOP;
      data_r <= '0;
`ifdef SWAP_ARB_WDOG_EN
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid_c) begin
            gnt    <= pick_gnt_c;
            gidx   <= pick_idx_c;
            op_r   <= pick_op_c;
            data_r <= pick_data_c;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_r)
            OP_LDB: begin
              b_q <= data_r;
`ifdef SWAP_ARB_WDOG_EN
              wdog_cnt <= '0;
`endif
            end
            OP_LDC: begin
              c_q <= data_r;
`ifdef SWAP_ARB_WDOG_EN
              wdog_cnt <= '0;
`endif
            end
            OP_SWAP: begin
`ifdef SWAP_ARB_WDOG_EN
              // At the limit the swap is dropped but still completes with done.
              if (wdog_cnt == CW'(WDOG_MAX)) begin
                wdog_trip <= 1'b1;
              end else begin
                b_q      <= c_q;
                c_q      <= b_q;
                wdog_cnt <= wdog_cnt + CW'(1);
              end
`else
              b_q <= c_q;
              c_q <= b_q;
`endif
            end
            default: ;
          endcase
          done  <= 1'b1;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold the grant until the owner withdraws its request.
          if (!(|(req & gnt))) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
